// File: rtl/pc_next_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_next_unit : registered PC with branch/JALR redirect, stall, halt, trap
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_next_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic         jalr_sel,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] jalr_addr,
  input  logic         halt_req,
  input  logic         resume,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic [N-1:0] branch_target,
  output logic         pc_valid,
  output logic         flush,
  output logic         misaligned
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [N-1:0] C_FOUR = N'(4);

  state_t       r_state, w_state_d;
  logic [N-1:0] r_pc, w_pc_d;
  logic         r_valid, w_valid_d;
  logic         r_flush, w_flush_d;
  logic         r_mis, w_mis_d;
  logic [N-1:0] w_jalr_target;
  logic [N-1:0] w_candidate;

  // imm is in half-words; the shift discards its top bit, wrapping mod 2^N
  assign branch_target = r_pc + (imm << 1);
  assign pc_plus4      = r_pc + C_FOUR;
  assign w_jalr_target = jalr_addr & ~N'(1);
  assign w_candidate   = jalr_sel ? w_jalr_target : branch_target;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_valid_d = r_valid;
    w_flush_d = 1'b0;
    w_mis_d   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_d = S_RUN;
        w_valid_d = 1'b1;
      end
      S_RUN: begin
        if (halt_req) begin
          w_state_d = S_HALT;
          w_valid_d = 1'b0;
        end else if (stall) begin
          w_pc_d = r_pc;
        end else if (jalr_sel || branch_taken) begin
          // no compressed ISA: a target off a word boundary traps to HALT
          if (w_candidate[1]) begin
            w_mis_d   = 1'b1;
            w_valid_d = 1'b0;
            w_state_d = S_HALT;
          end else begin
            w_pc_d    = w_candidate;
            w_flush_d = 1'b1;
          end
        end else begin
          w_pc_d = pc_plus4;
        end
      end
      S_HALT: begin
        w_valid_d = 1'b0;
        if (resume) begin
          w_state_d = S_RUN;
          w_valid_d = 1'b1;
        end
      end
      default: begin
        w_state_d = S_BOOT;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_valid <= w_valid_d;
      r_flush <= w_flush_d;
      r_mis   <= w_mis_d;
    end
  end

  assign pc         = r_pc;
  assign pc_valid   = r_valid;
  assign flush      = r_flush;
  assign misaligned = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_next_unit : directed plan plus random stimulus against a PC model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_next_unit;

  localparam int          N        = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst, stall, branch_taken, jalr_sel, halt_req, resume;
  logic [N-1:0] imm, jalr_addr;
  logic [N-1:0] pc, pc_plus4, branch_target;
  logic         pc_valid, flush, misaligned;

  pc_next_unit #(.N(N), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .jalr_sel(jalr_sel), .imm(imm), .jalr_addr(jalr_addr),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .pc_valid(pc_valid), .flush(flush),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: abstract machine status, not the RTL encoding
  bit          m_known   = 0;
  bit          m_booting = 0;
  bit          m_halted  = 0;
  bit          m_flush   = 0;
  bit          m_mis     = 0;
  logic [31:0] m_pc      = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, st, bt, js, input logic [31:0] im, ja,
                            input bit hr, rs);
    logic [31:0] tgt;
    m_flush = 0;
    m_mis   = 0;
    if (!r) begin
      m_known = 1; m_booting = 1; m_halted = 0; m_pc = RESET_PC;
    end else if (!m_known) begin
      // nothing known before the first reset
    end else if (m_booting) begin
      m_booting = 0;
    end else if (m_halted) begin
      if (rs) m_halted = 0;
    end else if (hr) begin
      m_halted = 1;
    end else if (st) begin
      // hold
    end else if (js || bt) begin
      tgt = js ? (ja / 2) * 2 : m_pc + im * 2;
      if (tgt % 4 != 0) begin
        m_halted = 1; m_mis = 1;
      end else begin
        m_pc = tgt; m_flush = 1;
      end
    end else begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic cycle(input bit r, st, bt, js, input logic [31:0] im, ja,
                       input bit hr, rs);
    rst = r; stall = st; branch_taken = bt; jalr_sel = js;
    imm = im; jalr_addr = ja; halt_req = hr; resume = rs;
    #1;
    if (m_known) begin
      chk("branch_target", branch_target, m_pc + im * 2);
      chk("pc_plus4", pc_plus4, m_pc + 4);
    end
    @(posedge clk);
    model_edge(r, st, bt, js, im, ja, hr, rs);
    #1;
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, !m_booting && !m_halted});
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    end
  endtask

  // convenience wrappers
  task automatic idle();                 cycle(1,0,0,0,0,0,0,0); endtask
  task automatic jump(input logic [31:0] a); cycle(1,0,0,1,0,a,0,0); endtask

  initial begin
    rst = 0; stall = 0; branch_taken = 0; jalr_sel = 0;
    imm = '0; jalr_addr = '0; halt_req = 0; resume = 0;
    @(negedge clk);

    // reset then run
    cycle(0,0,0,0,0,0,0,0);
    cycle(0,0,0,0,0,0,0,0);
    chk("reset_pc", pc, RESET_PC);
    chk("reset_valid", {31'd0, pc_valid}, 32'd0);
    idle();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    idle(); chk("run_pc4", pc, 32'h4);
    idle(); chk("run_pc8", pc, 32'h8);
    idle(); chk("run_pc12", pc, 32'hC);

    // branch backwards
    jump(32'h10);
    cycle(1,0,1,0,32'hFFFF_FFFC,0,0,0);
    chk("branch_pc", pc, 32'h08);
    chk("branch_flush", {31'd0, flush}, 32'd1);
    idle();
    chk("flush_once", {31'd0, flush}, 32'd0);

    // stall beats redirect, then JALR beats branch
    jump(32'h20);
    cycle(1,1,1,0,32'd8,0,0,0);
    chk("stall_pc", pc, 32'h20);
    cycle(1,0,1,1,32'd8,32'h41,0,0);
    chk("jalr_pc", pc, 32'h40);

    // misaligned branch traps, resume continues
    jump(32'h30);
    cycle(1,0,1,0,32'd1,0,0,0);
    chk("mis_pc", pc, 32'h30);
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    cycle(1,0,0,0,0,0,0,1);
    chk("resume_valid", {31'd0, pc_valid}, 32'd1);
    idle();
    chk("resume_pc", pc, 32'h34);

    // halt beats redirect; reset while halted
    jump(32'h50);
    cycle(1,0,1,0,32'd4,0,1,0);
    chk("halt_pc", pc, 32'h50);
    cycle(0,0,0,0,0,0,0,1);
    chk("halt_reset_pc", pc, RESET_PC);
    idle();

    // wrap-around
    jump(32'hFFFF_FFFC);
    idle();
    chk("wrap_pc", pc, 32'h0);
    jump(32'hFFFF_FFF0);
    cycle(1,0,0,0,32'h10,0,0,0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, st, bt, js, hr, rs;
      logic [31:0] im, ja;
      r  = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 4) == 0);
      bt = ($urandom_range(0, 3) == 0);
      js = ($urandom_range(0, 5) == 0);
      hr = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 2) == 0);
      im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      ja = $urandom;
      cycle(r, st, bt, js, im, ja, hr, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage of the single-cycle core.
- Takes the raw B/J-type immediate (half-word offset) and doubles it internally by a one-bit left shift. Forms the branch target, selects the next PC, and holds it in the PC register.
- Adds stall, halt/resume and misaligned-target trapping so that fetch and the control unit see one registered, valid-qualified PC.

Parameters:
- N, 32, datapath and PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- stall  input  1  holds the PC this cycle (hazard or memory wait).
- branch_taken  input  1  redirect to the PC-relative target (taken branch or JAL).
- jalr_sel  input  1  redirect to the register-relative target (JALR).
- imm  input  N  sign-extended immediate in half-word units, not yet shifted.
- jalr_addr  input  N  rs1+imm sum from the ALU.
- halt_req  input  1  ECALL/EBREAK/external halt request.
- resume  input  1  leave HALT.
- pc  output  N  current PC (registered).
- pc_plus4  output  N  pc+4 (combinational from pc).
- branch_target  output  N  pc + (imm<<1) (combinational).
- pc_valid  output  1  pc is a fetchable address this cycle (registered).
- flush  output  1  one-cycle pulse in the cycle after a redirect is accepted (registered).
- misaligned  output  1  one-cycle pulse: redirect target was not word-aligned (registered).

Behaviour:
- Arithmetic:
  - branch_target = pc + {imm[N-2:0],1'b0}, modulo 2^N; overflow wraps silently.
  - jalr_target = {jalr_addr[N-1:1],1'b0}, per the ISA.
  - pc_plus4 wraps modulo 2^N.
- FSM states: S_BOOT, S_RUN, S_HALT.
- Reset (rst==0 at a clock edge), overriding everything:
  - pc=RESET_PC, pc_valid=0, flush=0, misaligned=0, state=S_BOOT.
  - Asserting reset mid-operation, including in S_HALT, has the same effect.
- S_BOOT: lasts exactly one cycle after reset release. pc stays RESET_PC, pc_valid becomes 1, state goes to S_RUN. All other inputs are ignored.
- S_RUN: each edge applies the first matching rule, in this priority order:
  1. halt_req: pc holds, pc_valid=0, state goes to S_HALT. Any redirect in the same cycle is dropped.
  2. stall: pc holds. All redirect inputs are ignored; the control unit re-presents them.
  3. jalr_sel: candidate target = jalr_target.
  4. branch_taken: candidate target = branch_target. If jalr_sel and branch_taken are both high, jalr_sel wins.
  5. Otherwise pc <= pc_plus4.
- Redirect candidate (rules 3 or 4):
  - If candidate[1]==0: pc <= candidate, and flush=1 on the next cycle.
  - If candidate[1]==1 (no C extension): pc holds, misaligned=1 for one cycle, pc_valid=0, state goes to S_HALT. No flush is issued.
- flush and misaligned are each high for exactly one cycle per event. Otherwise they are 0.
- S_HALT:
  - pc holds and pc_valid=0.
  - stall, redirect and halt_req are ignored.
  - resume moves the state to S_RUN with pc_valid=1 on the next cycle, and pc continues from the held value.
  - resume in any other state is ignored.
- Latency: one clock from the select inputs to the new pc. branch_target and pc_plus4 have zero latency from pc.

Test Plan:
- Reset then run: rst low for 2 cycles, then high, with no other inputs. pc=0 with pc_valid=0 during reset; pc=0 with pc_valid=1 at the first edge after release; then pc=4, 8, 12 on following edges.
- Branch: at pc=0x10, imm=-4 (0xFFFF_FFFC), branch_taken=1. branch_target=0x08 combinationally; next pc=0x08 and flush=1 for exactly one cycle.
- Priority and stall: at pc=0x20, stall=1, branch_taken=1, imm=8 gives pc 0x20 held with no flush. Release stall with jalr_sel=1, jalr_addr=0x41, branch_taken=1: pc=0x40 (JALR wins, bit0 cleared), then flush.
- Misaligned: at pc=0x30, branch_taken=1, imm=1 (target 0x32). pc stays 0x30, misaligned pulses once, pc_valid=0 and state is HALT. resume=1 gives pc_valid=1, then pc=0x34.
- Halt vs redirect: halt_req=1 together with branch_taken=1 at pc=0x50. pc stays 0x50, no flush, pc_valid=0. Asserting rst low while halted gives pc=RESET_PC and S_BOOT.
- Wrap-around: pc=0xFFFF_FFFC with no redirect gives next pc=0x0000_0000. At pc=0xFFFF_FFF0 with imm=0x10 (byte offset 0x20), branch_target=0x0000_0010.
